// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared types and elaboration-time helpers for serial_adder.
//   state_e        : control FSM states (IDLE, RUN, DONE)
//   calc_nsteps    : number of digit steps needed to cover WIDTH bits
//   calc_cnt_width : width of the step counter, clog2(nsteps + 1)
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // A zero digit is rejected by the top-level parameter check; return 1
    // here so the division never faults during elaboration.
    function automatic int calc_nsteps(input int width, input int digit);
        return (digit > 0) ? (width / digit) : 1;
    endfunction

    function automatic int calc_cnt_width(input int nsteps);
        return $clog2(nsteps + 1);
    endfunction

endpackage

// File: rtl/serial_adder_fa_cell.sv
// fa_cell: combinational 1-bit full adder, one link of the digit chain.
//   a, b : operand bits
//   ci   : carry in
//   s    : sum bit
//   co   : carry out
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic p;

    assign p  = a ^ b;
    assign s  = p ^ ci;
    assign co = (a & b) | (ci & p);

endmodule

// File: rtl/serial_adder.sv
// serial_adder: multi-cycle adder that sums two WIDTH-bit operands plus a
// carry-in, DIGIT bits per clock, through a ripple chain of DIGIT fa_cells.
// The carry between digit steps lives in a flop.
//
// Parameters: WIDTH (operand/sum width), DIGIT (bits per cycle, divides WIDTH).
// Ports:
//   clk, rst         : rising-edge clock, asynchronous active-high reset
//   in_valid/ready   : operand handshake (a, b, c_in)
//   out_valid/ready  : result handshake (sum, c_out)
//   sub, ovf         : only with SERIAL_ADDER_SUB_EN; sub selects a - b - c_in,
//                      ovf flags signed two's-complement overflow
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high only in IDLE; out_valid is high only in DONE,
// where sum/c_out are held until out_ready is seen.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
    output logic             ovf,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);

    localparam int NSTEPS = calc_nsteps(WIDTH, DIGIT);
    localparam int CW     = calc_cnt_width(NSTEPS);
    localparam logic [CW-1:0] LAST = CW'(NSTEPS - 1);

    if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
        $error("serial_adder: WIDTH must be >= 1 and an integer multiple of DIGIT");
    end

    state_e            state;
    state_e            state_next;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic [WIDTH-1:0]  sum_q;
    logic [WIDTH-1:0]  sum_next;
    logic              carry_q;
    logic              c_out_q;
    logic [CW-1:0]     cnt_q;
    logic [DIGIT:0]    chain_c;
    logic [DIGIT-1:0]  digit_s;
    logic [WIDTH-1:0]  b_load;
    logic              carry_load;
    logic              accept;
    logic              last_step;

    assign accept    = in_valid && (state == IDLE);
    assign last_step = (state == RUN) && (cnt_q == LAST);

    // Subtraction is a + ~b + 1 - c_in, so b is inverted on the way in and
    // the carry flop starts at ~c_in.
`ifdef SERIAL_ADDER_SUB_EN
    logic ovf_q;
    assign b_load     = sub ? ~b : b;
    assign carry_load = sub ? ~c_in : c_in;
    assign ovf        = ovf_q;
`else
    assign b_load     = b;
    assign carry_load = c_in;
`endif

    // Ripple chain over the DIGIT least-significant bits of the shift regs.
    assign chain_c[0] = carry_q;
    for (genvar i = 0; i < DIGIT; i++) begin : g_cell
        fa_cell u_fa (
            .a  (a_q[i]),
            .b  (b_q[i]),
            .ci (chain_c[i]),
            .s  (digit_s[i]),
            .co (chain_c[i+1])
        );
    end

    // New digit enters at the MSB end; after NSTEPS shifts the first digit
    // has reached bit 0.
    if (NSTEPS == 1) begin : g_single
        assign sum_next = digit_s;
    end else begin : g_multi
        assign sum_next = {digit_s, sum_q[WIDTH-1:DIGIT]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            c_out_q <= 1'b0;
            cnt_q   <= '0;
`ifdef SERIAL_ADDER_SUB_EN
            ovf_q   <= 1'b0;
`endif
        end else if (accept) begin
            a_q     <= a;
            b_q     <= b_load;
            carry_q <= carry_load;
            cnt_q   <= '0;
        end else if (state == RUN) begin
            a_q     <= a_q >> DIGIT;
            b_q     <= b_q >> DIGIT;
            sum_q   <= sum_next;
            carry_q <= chain_c[DIGIT];
            c_out_q <= chain_c[DIGIT];
            cnt_q   <= cnt_q + CW'(1);
`ifdef SERIAL_ADDER_SUB_EN
            // On the last step the top cell is the word MSB.
            if (last_step) begin
                ovf_q <= chain_c[DIGIT] ^ chain_c[DIGIT-1];
            end
`endif
        end
    end

    assign sum   = sum_q;
    assign c_out = c_out_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed and randomised checks of serial_adder with
// DIGIT=1 (u_dut1) and DIGIT=4 (u_dut4), both WIDTH=8, sharing operands.
// Expected {ovf, c_out, sum} words come from an integer model and are
// queued when operands are driven, then popped when out_valid appears.
// Sub-mode steps are built only when SERIAL_ADDER_SUB_EN is defined.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] a;
    logic [7:0] b;
    logic       c_in;
    logic       in_valid1, in_ready1, out_valid1, out_ready1, c_out1;
    logic       in_valid4, in_ready4, out_valid4, out_ready4, c_out4;
    logic [7:0] sum1;
    logic [7:0] sum4;
`ifdef SERIAL_ADDER_SUB_EN
    logic       sub;
    logic       ovf1;
    logic       ovf4;
`endif

    int total = 0;
    int bad   = 0;
    logic [9:0] exp_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    serial_adder #(.WIDTH(8), .DIGIT(1)) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
`ifdef SERIAL_ADDER_SUB_EN
        .sub       (sub),
        .ovf       (ovf1),
`endif
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .sum       (sum1),
        .c_out     (c_out1)
    );

    serial_adder #(.WIDTH(8), .DIGIT(4)) u_dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
`ifdef SERIAL_ADDER_SUB_EN
        .sub       (sub),
        .ovf       (ovf4),
`endif
        .out_valid (out_valid4),
        .out_ready (out_ready4),
        .sum       (sum4),
        .c_out     (c_out4)
    );

    // ---------------- model ----------------
    // Returns {ovf, c_out, sum}. For subtraction c_out=1 means no borrow.
    function automatic logic [9:0] model(input logic [7:0] av, input logic [7:0] bv,
                                         input logic ci, input logic sb);
        int r;
        int sr;
        int sa;
        int sbv;
        logic [9:0] res;
        sa  = $signed(av);
        sbv = $signed(bv);
        if (sb) begin
            r  = int'(av) - int'(bv) - int'(ci);
            sr = sa - sbv - int'(ci);
            res[8] = (r >= 0);
        end else begin
            r  = int'(av) + int'(bv) + int'(ci);
            sr = sa + sbv + int'(ci);
            res[8] = (r > 255);
        end
        res[7:0] = r[7:0];
        res[9]   = (sr > 127) || (sr < -128);
        return res;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic accept_op(input bit sel4, input logic [7:0] av, input logic [7:0] bv,
                             input logic ci, input logic sb);
        int   n;
        logic rdy;
        a    = av;
        b    = bv;
        c_in = ci;
`ifdef SERIAL_ADDER_SUB_EN
        sub  = sb;
`endif
        if (sel4) in_valid4 = 1'b1; else in_valid1 = 1'b1;
        n   = 0;
        rdy = sel4 ? in_ready4 : in_ready1;
        while (!rdy && n < 40) begin
            @(posedge clk); #1;
            n++;
            rdy = sel4 ? in_ready4 : in_ready1;
        end
        check("accept_wait", 32'(rdy), 32'd1);
        exp_q.push_back(model(av, bv, ci, sb));
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        in_valid4 = 1'b0;
    endtask

    task automatic collect_op(input bit sel4, input string tag, input int exp_lat);
        int         n;
        logic       v;
        logic       seen_ready;
        logic [9:0] e;
        n          = 0;
        seen_ready = 1'b0;
        v          = sel4 ? out_valid4 : out_valid1;
        while (!v && n < 40) begin
            if (sel4 ? in_ready4 : in_ready1) seen_ready = 1'b1;
            @(posedge clk); #1;
            n++;
            v = sel4 ? out_valid4 : out_valid1;
        end
        if (sel4 ? in_ready4 : in_ready1) seen_ready = 1'b1;
        check({tag, "_latency"}, 32'(n), 32'(exp_lat));
        check({tag, "_in_ready_low"}, 32'(seen_ready), 32'd0);
        check({tag, "_queue"}, 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, "_sum"}, 32'(sel4 ? sum4 : sum1), 32'(e[7:0]));
            check({tag, "_c_out"}, 32'(sel4 ? c_out4 : c_out1), 32'(e[8]));
`ifdef SERIAL_ADDER_SUB_EN
            check({tag, "_ovf"}, 32'(sel4 ? ovf4 : ovf1), 32'(e[9]));
`endif
        end
    endtask

    task automatic release_op(input bit sel4, input string tag);
        if (sel4) out_ready4 = 1'b1; else out_ready1 = 1'b1;
        @(posedge clk); #1;
        out_ready1 = 1'b0;
        out_ready4 = 1'b0;
        check({tag, "_rel_in_ready"}, 32'(sel4 ? in_ready4 : in_ready1), 32'd1);
        check({tag, "_rel_out_valid"}, 32'(sel4 ? out_valid4 : out_valid1), 32'd0);
    endtask

    task automatic full_op(input bit sel4, input logic [7:0] av, input logic [7:0] bv,
                           input logic ci, input logic sb, input string tag);
        accept_op(sel4, av, bv, ci, sb);
        collect_op(sel4, tag, sel4 ? 2 : 8);
        release_op(sel4, tag);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rc;
        logic       rs;

        rst        = 1'b1;
        a          = '0;
        b          = '0;
        c_in       = 1'b0;
        in_valid1  = 1'b0;
        in_valid4  = 1'b0;
        out_ready1 = 1'b0;
        out_ready4 = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        sub        = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        check("reset_in_ready1", 32'(in_ready1), 32'd1);
        check("reset_out_valid1", 32'(out_valid1), 32'd0);
        check("reset_sum1", 32'(sum1), 32'd0);
        check("reset_c_out1", 32'(c_out1), 32'd0);
        check("reset_in_ready4", 32'(in_ready4), 32'd1);
        check("reset_sum4", 32'(sum4), 32'd0);

        full_op(1'b0, 8'h5A, 8'h3C, 1'b0, 1'b0, "add_5a_3c");
        full_op(1'b0, 8'hFF, 8'h01, 1'b0, 1'b0, "add_ff_01");
        full_op(1'b0, 8'hFF, 8'hFF, 1'b1, 1'b0, "add_ff_ff_c1");

        // Backpressure: result must hold in DONE and a new in_valid is ignored.
        accept_op(1'b0, 8'h33, 8'h44, 1'b0, 1'b0);
        collect_op(1'b0, "bp", 8);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                a         = 8'h11;
                b         = 8'h22;
                in_valid1 = 1'b1;
            end
            @(posedge clk); #1;
            in_valid1 = 1'b0;
        end
        check("bp_out_valid_held", 32'(out_valid1), 32'd1);
        check("bp_sum_held", 32'(sum1), 32'h77);
        check("bp_c_out_held", 32'(c_out1), 32'd0);
        release_op(1'b0, "bp");
        @(posedge clk); #1;
        check("bp_idle_sum_held", 32'(sum1), 32'h77);
        check("bp_idle_no_run", 32'(in_ready1), 32'd1);

        // Asynchronous reset partway through a run; the partial result is dropped.
        accept_op(1'b0, 8'h5A, 8'h3C, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        exp_q.delete();
        check("midrst_in_ready", 32'(in_ready1), 32'd1);
        check("midrst_out_valid", 32'(out_valid1), 32'd0);
        check("midrst_sum", 32'(sum1), 32'd0);
        check("midrst_c_out", 32'(c_out1), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        full_op(1'b0, 8'h01, 8'h02, 1'b0, 1'b0, "after_rst");

        full_op(1'b1, 8'h5A, 8'h3C, 1'b1, 1'b0, "d4_5a_3c_c1");
        full_op(1'b1, 8'hFF, 8'h01, 1'b0, 1'b0, "d4_ff_01");

        for (int i = 0; i < 8; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rc = 1'($urandom_range(0, 1));
`ifdef SERIAL_ADDER_SUB_EN
            rs = 1'($urandom_range(0, 1));
`else
            rs = 1'b0;
`endif
            full_op(1'(i % 2), ra, rb, rc, rs, "rand");
        end

`ifdef SERIAL_ADDER_SUB_EN
        full_op(1'b0, 8'h10, 8'h01, 1'b0, 1'b1, "sub_10_01");
        full_op(1'b0, 8'h80, 8'h01, 1'b0, 1'b1, "sub_80_01");
        full_op(1'b1, 8'h80, 8'h01, 1'b0, 1'b1, "d4_sub_80_01");
        full_op(1'b1, 8'h01, 8'h02, 1'b0, 1'b1, "d4_sub_borrow");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
